// File: rtl/led_pkg.sv
// led_pkg: shared defaults and types for the led_scanner display driver.
// Optional blanking phase is compiled in with LED_SCAN_BLANK_EN.
package led_pkg;

  localparam int LED_DIGITS = 8;
  localparam int LED_SEG_W  = 8;

  typedef logic [LED_SEG_W-1:0] seg_t;

  typedef enum logic [1:0] {
    LOAD,
    SHOW,
    BLANK
  } scan_phase_t;

endpackage

// File: rtl/led_scan_prescaler.sv
// led_scan_prescaler: counts how long the current digit slot has been driven
// (DWELL cycles in SHOW, BLANK_CYC cycles in BLANK when LED_SCAN_BLANK_EN is
// defined) and flags the last cycle of the slot with slot_done.
module led_scan_prescaler
  import led_pkg::*;
#(
  parameter int DWELL     = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  scan_phase_t phase,
  output logic        slot_done
);

  localparam int MAX_CYC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

`ifdef LED_SCAN_BLANK_EN
  assign limit = (phase == BLANK) ? CNT_W'(BLANK_CYC - 1) : CNT_W'(DWELL - 1);
`else
  assign limit = CNT_W'(DWELL - 1);
`endif

  // LOAD never counts: slot_done is ignored there and the counter is held at 0.
  assign slot_done = (phase != LOAD) && (cnt == limit);

  // Free-running slot counter, restarted at every phase or digit change.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      cnt <= '0;
    end else if (phase == LOAD || slot_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// led_scanner: time-multiplexed 7-segment driver. Snapshots DIGITS segment
// patterns once per frame and scans them onto one segment bus with a rotating
// one-hot digit select. Define LED_SCAN_BLANK_EN to insert a BLANK_CYC-long
// dark gap after every digit (anti-ghosting).
module led_scanner
  import led_pkg::*;
#(
  parameter int DIGITS    = LED_DIGITS,
  parameter int SEG_W     = LED_SEG_W,
  parameter int DWELL     = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIGITS*SEG_W-1:0] seg_in,
  input  logic [DIGITS-1:0]       dig_en,
  output logic [SEG_W-1:0]        seg_out,
  output logic [DIGITS-1:0]       controll,
  output logic                    frame_tick
);

  localparam int                IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DIGITS - 1);

  scan_phase_t             phase, phase_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    load;
  logic                    slot_done;

  logic [DIGITS*SEG_W-1:0] buf_seg;
  logic [DIGITS-1:0]       buf_en;

  // Values the output registers are computed from on the next edge.
  logic [DIGITS*SEG_W-1:0] src_seg;
  logic [DIGITS-1:0]       src_en;
  logic                    show_nxt;
  logic [SEG_W-1:0]        seg_nxt;
  logic [DIGITS-1:0]       ctl_nxt;

  led_scan_prescaler #(
    .DWELL     (DWELL),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .phase     (phase),
    .slot_done (slot_done)
  );

  // Phase FSM: a frame reload happens on the same edge that ends the last
  // digit's slot, so LOAD itself is only ever occupied after reset.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    phase_nxt = phase;
    idx_nxt   = idx;
    load      = 1'b0;
    case (phase)
      LOAD: load = 1'b1;
      SHOW: begin
        if (slot_done) begin
`ifdef LED_SCAN_BLANK_EN
          phase_nxt = BLANK;
`else
          if (idx == LAST) load = 1'b1;
          else             idx_nxt = idx + 1'b1;
`endif
        end
      end
      BLANK: begin
        if (slot_done) begin
          if (idx == LAST) begin
            load = 1'b1;
          end else begin
            idx_nxt   = idx + 1'b1;
            phase_nxt = SHOW;
          end
        end
      end
      default: phase_nxt = LOAD;
    endcase
    if (load) begin
      phase_nxt = SHOW;
      idx_nxt   = '0;
    end
  end

  // Output values for the upcoming state; on a reload the fresh inputs are
  // used directly since the buffers capture them on that same edge.
  always_comb begin
    src_seg  = load ? seg_in : buf_seg;
    src_en   = load ? dig_en : buf_en;
    show_nxt = (phase_nxt == SHOW) && src_en[idx_nxt];
    seg_nxt  = show_nxt ? src_seg[idx_nxt*SEG_W +: SEG_W] : '0;
    ctl_nxt  = show_nxt ? (DIGITS'(1) << idx_nxt) : '0;
  end

  // State, frame buffers and registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= LOAD;
      idx        <= '0;
      // NOTE: the frame buffers are cleared on reset so the design starts from
      // a known, dark snapshot rather than stale pattern data.
      buf_seg    <= '0;
      buf_en     <= '0;
      seg_out    <= '0;
      controll   <= '0;
      frame_tick <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      idx        <= idx_nxt;
      if (load) begin
        buf_seg  <= seg_in;
        buf_en   <= dig_en;
      end
      seg_out    <= seg_nxt;
      controll   <= ctl_nxt;
      frame_tick <= load;
    end
  end

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: self-checking bench for led_scanner. Two instances run side
// by side (DWELL=4 and DWELL=1, BLANK_CYC=2); a frame-position model predicts
// every output cycle. Honours LED_SCAN_BLANK_EN when defined for the build.
module tb_led_scanner;

`ifdef LED_SCAN_BLANK_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif
  localparam int SLOT0  = 4 + BLK;
  localparam int FRAME0 = 8 * SLOT0;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] seg_in;
  logic [7:0]  dig_en;
  logic [7:0]  seg0, ctl0, seg1, ctl1;
  logic        tick0, tick1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_scanner #(.DIGITS(8), .SEG_W(8), .DWELL(4), .BLANK_CYC(2)) dut0 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dig_en(dig_en),
    .seg_out(seg0), .controll(ctl0), .frame_tick(tick0)
  );

  led_scanner #(.DIGITS(8), .SEG_W(8), .DWELL(1), .BLANK_CYC(2)) dut1 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dig_en(dig_en),
    .seg_out(seg1), .controll(ctl1), .frame_tick(tick1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is 8 slots of (dwell + blank) cycles; pos is the index of the
  // output cycle within the frame, snapshots taken at each frame start.
  bit         started [2];
  int         pos     [2];
  logic [7:0] snap_seg[2][8];
  logic [7:0] snap_en [2];
  logic [7:0] exp_seg [2];
  logic [7:0] exp_ctl [2];
  logic       exp_tick[2];
  int         m_dw, m_slot, m_frame, m_d, m_off;
  bit         m_shown;

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      m_dw    = (m == 0) ? 4 : 1;
      m_slot  = m_dw + BLK;
      m_frame = 8 * m_slot;
      if (reset) begin
        started[m]  = 1'b0;
        exp_seg[m]  = '0;
        exp_ctl[m]  = '0;
        exp_tick[m] = 1'b0;
      end else begin
        if (!started[m] || pos[m] == m_frame - 1) begin
          for (int d = 0; d < 8; d++) snap_seg[m][d] = seg_in[d*8 +: 8];
          snap_en[m] = dig_en;
          pos[m]     = 0;
          started[m] = 1'b1;
        end else begin
          pos[m] = pos[m] + 1;
        end
        m_d     = pos[m] / m_slot;
        m_off   = pos[m] % m_slot;
        m_shown = (m_off < m_dw) && snap_en[m][m_d];
        exp_seg[m]  = m_shown ? snap_seg[m][m_d] : 8'h00;
        exp_ctl[m]  = m_shown ? (8'h01 << m_d) : 8'h00;
        exp_tick[m] = (pos[m] == 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit comp_en = 1'b0;

  always @(negedge clk) begin
    if (comp_en) begin
      check("cyc_seg_dw4",  seg0,  exp_seg[0]);
      check("cyc_ctl_dw4",  ctl0,  exp_ctl[0]);
      check("cyc_tick_dw4", tick0, exp_tick[0]);
      check("cyc_seg_dw1",  seg1,  exp_seg[1]);
      check("cyc_ctl_dw1",  ctl1,  exp_ctl[1]);
      check("cyc_tick_dw1", tick1, exp_tick[1]);
      check("onehot_dw4",   ($countones(ctl0) <= 1), 1);
      check("onehot_dw1",   ($countones(ctl1) <= 1), 1);
    end
  end

  // ---------------- directed stimulus ----------------
  int p;  // output-cycle position of dut0 within its frame

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    p = (p + n) % FRAME0;
  endtask

  task automatic adv_to(input int target);
    adv(((target - p) + FRAME0) % FRAME0);
  endtask

  task automatic set_digit(input int d, input logic [7:0] v);
    @(negedge clk);
    seg_in[d*8 +: 8] = v;
  endtask

  initial begin
    p      = 0;
    reset  = 1'b1;
    dig_en = 8'hFF;
    for (int d = 0; d < 8; d++) seg_in[d*8 +: 8] = 8'(d + 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg",  seg0,  8'h00);
    check("rst_ctl",  ctl0,  8'h00);
    check("rst_tick", tick0, 1'b0);
    comp_en = 1'b1;

    // First frame after release: digit 0 and tick one cycle after first edge.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_ctl",     ctl0,  8'h01);
    check("first_seg",     seg0,  8'h01);
    check("first_tick",    tick0, 1'b1);
    check("first_ctl_dw1", ctl1,  8'h01);
    adv(1);
    check("tick_drop", tick0, 1'b0);
    check("dwell_ctl", ctl0,  8'h01);
`ifdef LED_SCAN_BLANK_EN
    adv_to(4);
    check("blank_ctl", ctl0, 8'h00);
    check("blank_seg", seg0, 8'h00);
    adv_to(6);
`else
    adv_to(4);
`endif
    check("dig1_ctl", ctl0, 8'h02);
    check("dig1_seg", seg0, 8'h02);
    adv_to(FRAME0 - 1);
`ifdef LED_SCAN_BLANK_EN
    check("last_cyc_ctl", ctl0, 8'h00);
`else
    check("last_cyc_ctl", ctl0, 8'h80);
    check("last_cyc_seg", seg0, 8'h08);
`endif
    check("last_cyc_tick", tick0, 1'b0);
    adv(1);
    check("frame2_tick", tick0, 1'b1);
    check("frame2_ctl",  ctl0,  8'h01);

    // Digit 5 becomes 3F mid-frame 2: frame 2 keeps 06.
    set_digit(5, 8'h3F);
    adv_to(5 * SLOT0);
    check("f2_dig5_seg", seg0, 8'h06);
    adv_to(0);
    // Frame 3: change digit 5 to 06 while digit 2 is on the pins.
    adv_to(2 * SLOT0 + 1);
    check("f3_dig2_ctl", ctl0, 8'h04);
    set_digit(5, 8'h06);
    adv_to(5 * SLOT0);
    check("f3_dig5_seg", seg0, 8'h3F);
    check("f3_dig5_ctl", ctl0, 8'h20);
    adv_to(0);
    adv_to(5 * SLOT0);
    check("f4_dig5_seg", seg0, 8'h06);

    // Disable digits 0-3 from the next frame on.
    @(negedge clk);
    dig_en = 8'b1111_0000;
    adv_to(0);
    check("en_tick",     tick0, 1'b1);
    check("en_dig0_ctl", ctl0,  8'h00);
    check("en_dig0_seg", seg0,  8'h00);
    adv_to(4 * SLOT0);
    check("en_dig4_ctl", ctl0, 8'h10);
    check("en_dig4_seg", seg0, 8'h05);

    // Reset pulse during digit 3 of a frame.
    adv_to(0);
    @(negedge clk);
    dig_en = 8'hFF;
    adv_to(3 * SLOT0 + 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ctl",  ctl0,  8'h00);
    check("midrst_seg",  seg0,  8'h00);
    check("midrst_tick", tick0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    p = 0;
    check("restart_tick",    tick0, 1'b1);
    check("restart_ctl",     ctl0,  8'h01);
    check("restart_seg",     seg0,  8'h01);
    check("restart_ctl_dw1", ctl1,  8'h01);
    adv(1);
`ifdef LED_SCAN_BLANK_EN
    check("dw1_second_ctl", ctl1, 8'h00);
`else
    check("dw1_second_ctl", ctl1, 8'h02);
    check("dw1_second_seg", seg1, 8'h02);
`endif

    // Let both instances run through two more full frames under the model.
    adv(2 * FRAME0);
    @(negedge clk);
    comp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
# led_scanner

Time-multiplexed 7-segment display driver placed directly downstream of the eight-digit counter/decoder stage. It takes eight parallel segment patterns (digit 0 = least significant) and scans them onto a single segment bus with a rotating one-hot digit select (`controll`), so all eight digits appear lit at once. Inputs are snapshotted once per frame to prevent tearing when the upstream counter changes mid-scan.

## Interface
- `DIGITS`, 8, number of digits scanned (≥2)
- `SEG_W`, 8, segment bits per digit (7 segments + dp)
- `DWELL`, 1024, clock cycles each digit is driven (≥1)
- `BLANK_CYC`, 16, blanking cycles after each digit when blanking is compiled in (≥1)

- `clk`  in  1  single system clock
- `reset`  in  1  synchronous, active-high reset
- `seg_in`  in  DIGITS×SEG_W  packed segment patterns, active-high; digit i in bits [i*SEG_W +: SEG_W]
- `dig_en`  in  DIGITS  per-digit enable; 0 = digit slot kept but blank
- `seg_out`  out  SEG_W  segment bus to display, active-high, registered
- `controll`  out  DIGITS  one-hot digit select, active-high, registered
- `frame_tick`  out  1  one-cycle pulse on first output cycle of each frame

## Operation
- Internal state: `idx` (digit index, 0..DIGITS-1), `cnt` (dwell/blank counter), `phase` ∈ {LOAD, SHOW, BLANK}, frame buffers `buf_seg`, `buf_en`.
- LOAD: entered from reset and at end of last digit's slot; on that edge capture `seg_in`→`buf_seg`, `dig_en`→`buf_en`, set `idx`=0, `cnt`=0, go to SHOW, raise `frame_tick`. LOAD is not a dwell cycle; no extra cycle is spent in it.
- SHOW: `seg_out` = `buf_seg[idx]`, `controll` = one-hot(`idx`), both forced to 0 if `buf_en[idx]`=0. Stay DWELL cycles.
- End of SHOW: with blanking → BLANK; without → next digit (`idx`+1) or LOAD if `idx`=DIGITS-1.
- BLANK: `seg_out`=0, `controll`=0 for BLANK_CYC cycles, then next digit or LOAD.
- `cnt` resets to 0 on every phase change; width $clog2(max(DWELL,BLANK_CYC)+1).
- Changes on `seg_in`/`dig_en` mid-frame are invisible until next frame.
- At most one bit of `controll` is ever high.

## Timing
- While `reset` sampled high: `seg_out`=0, `controll`=0, `frame_tick`=0, `idx`=0, `cnt`=0, `phase`=LOAD, buffers cleared.
- First rising edge with `reset` low: buffers loaded; outputs show digit 0 and `frame_tick`=1 in the following cycle (latency 1 from input to pins).
- Digit i is driven for exactly DWELL consecutive cycles; frame period = DIGITS×DWELL (no blanking) or DIGITS×(DWELL+BLANK_CYC).
- `frame_tick` high for exactly 1 cycle per frame, coincident with first SHOW cycle of digit 0.
- Reset asserted mid-frame: outputs 0 on the next edge; restart from LOAD on release.
- DWELL=1: digit changes every cycle; wrap from DIGITS-1 to 0 without a gap.

## Configuration
- `LED_SCAN_BLANK_EN` defined: BLANK phase inserted after every digit (anti-ghosting), frame = DIGITS×(DWELL+BLANK_CYC).
- Undefined: BLANK state and BLANK_CYC logic removed; digits back-to-back; BLANK_CYC ignored.

## Structure
- Shared package `led_pkg`: `DIGITS`/`SEG_W` defaults, `seg_t` (logic [SEG_W-1:0]), `scan_phase_t` enum {LOAD, SHOW, BLANK}.
- One sub-module: `led_scan_prescaler` — counts DWELL/BLANK_CYC, emits `slot_done`; top holds `idx`, phase FSM, buffers and output registers.

## Test plan
- DWELL=4, no blanking, `seg_in` digits = 8'h01..8'h08, `dig_en`=8'hFF -> `controll` 01,02,…,80 each 4 cycles, `seg_out` 01..08 matching; `frame_tick` every 32 cycles.
- `LED_SCAN_BLANK_EN`, DWELL=4, BLANK_CYC=2 -> 4 cycles digit, 2 cycles `seg_out`=0/`controll`=0; frame 48 cycles.
- `dig_en`=8'b1111_0000 -> digits 0–3 slots have `seg_out`=0, `controll`=0; digits 4–7 driven normally, timing unchanged.
- Change `seg_in` digit 5 from 8'h3F to 8'h06 while digit 2 displayed -> digit 5 still shows 8'h3F this frame, 8'h06 next frame.
- Assert `reset` during digit 3 for 1 cycle -> outputs 0 next cycle; after release digit 0 shown with `frame_tick`=1 one cycle after first non-reset edge.
- DWELL=1 -> `controll` rotates every cycle, 80→01 wrap with no idle cycle; `controll` always one-hot or zero.
